// File: rtl/debug_pkg.sv
// Shared definitions for the debug controller.
// Contents: top-level FSM encoding (also driven out on state_o), dump sub-phases,
// UART command bytes and the end-of-program marker word.
package debug_pkg;

    localparam int unsigned NB_BYTE = 8;

    typedef enum logic [2:0] {
        StLoad = 3'd0,
        StCmd  = 3'd1,
        StStep = 3'd2,
        StRun  = 3'd3,
        StDump = 3'd4
    } state_e;

    // Which word of the dump is being sent.
    typedef enum logic [1:0] {
        PhPc  = 2'd0,
        PhCnt = 2'd1,
        PhReg = 2'd2,
        PhMem = 2'd3
    } dump_phase_e;

    // Per-word sequence: present address, latch read data, wait for serialiser.
    typedef enum logic [1:0] {
        StepAddr  = 2'd0,
        StepLatch = 2'd1,
        StepSend  = 2'd2
    } dump_step_e;

    localparam logic [7:0] CMD_STEP  = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;
    localparam logic [7:0] CMD_DUMP  = 8'h03;
    localparam logic [7:0] CMD_LOAD  = 8'h04;
    localparam logic [7:0] CMD_BREAK = 8'h05;

    // All-ones terminator; sliced down to the machine word width by users.
    localparam logic [63:0] END_OF_PROGRAM = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/debug_word_tx.sv
// Word serialiser for the debug dump.
// A start_i pulse latches word_i; the word then leaves as NB_DATA/8 bytes, LSB first,
// one tx_start_o pulse per byte, each waiting for tx_done_i before the next.
// done_o pulses once after the last byte's tx_done_i.
// Ports: clock_i, reset_i (sync, active high), start_i, word_i, tx_data_o, tx_start_o,
//        tx_done_i, done_o.
module debug_word_tx
    import debug_pkg::*;
#(
    parameter int unsigned NB_DATA = 32
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [NB_DATA-1:0] word_i,
    output logic [7:0]         tx_data_o,
    output logic               tx_start_o,
    input  logic               tx_done_i,
    output logic               done_o
);

    localparam int unsigned N_BYTES = NB_DATA / NB_BYTE;
    localparam int unsigned NB_IDX  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    logic               busy_q, busy_d;
    logic [NB_IDX-1:0]  idx_q, idx_d;
    logic [NB_DATA-1:0] shift_q, shift_d;
    logic [7:0]         data_q, data_d;
    logic               start_q, start_d;
    logic               done_q, done_d;

    always_comb begin
        busy_d  = busy_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        if (!busy_q) begin
            if (start_i) begin
                busy_d  = 1'b1;
                idx_d   = '0;
                data_d  = word_i[7:0];
                shift_d = word_i >> NB_BYTE;
                start_d = 1'b1;
            end
        // A done coinciding with our own start pulse cannot belong to this byte.
        end else if (tx_done_i && !start_q) begin
            if (idx_q == NB_IDX'(N_BYTES - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                idx_d   = idx_q + NB_IDX'(1);
                data_d  = shift_q[7:0];
                shift_d = shift_q >> NB_BYTE;
                start_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            busy_q  <= 1'b0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    assign tx_data_o  = data_q;
    assign tx_start_o = start_q;
    assign done_o     = done_q;

endmodule

// File: rtl/debug_ctrl_v2.sv
// Debug controller between the UART byte stream and the MIPS pipeline.
// LOAD assembles rx bytes (LSB first) into instruction words and writes them until the
// all-ones terminator or the last address; CMD decodes run-control bytes; STEP/RUN gate
// the pipeline; DUMP sends PC, [cycle count], registers and data memory over UART.
// Optional feature macro: DEBUG_CYCLE_COUNT_EN adds the cycle counter and its dump word.
// Ports: clock_i/reset_i (sync, active high); rx_data_i/rx_valid_i from UART rx;
//        tx_data_o/tx_start_o/tx_done_i to UART tx; instr_* program write port;
//        en_pipeline_o, halt_i, pc_i pipeline control; reg_*/mem_* debug read ports
//        (1-cycle read latency); state_o current FSM state.
module debug_ctrl_v2
    import debug_pkg::*;
#(
    parameter int unsigned NB_DATA       = 32,
    parameter int unsigned NB_REG        = 5,
    parameter int unsigned N_REGISTER    = 32,
    parameter int unsigned NB_ADDR       = 7,
    parameter int unsigned N_MEMORY_DATA = 128
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [7:0]         rx_data_i,
    input  logic               rx_valid_i,
    output logic [7:0]         tx_data_o,
    output logic               tx_start_o,
    input  logic               tx_done_i,
    output logic [NB_DATA-1:0] instr_data_o,
    output logic [NB_ADDR-1:0] instr_addr_o,
    output logic               instr_we_o,
    output logic               en_pipeline_o,
    input  logic               halt_i,
    input  logic [NB_DATA-1:0] pc_i,
    output logic               reg_sel_o,
    output logic [NB_REG-1:0]  reg_addr_o,
    input  logic [NB_DATA-1:0] reg_data_i,
    output logic               mem_sel_o,
    output logic [NB_ADDR-1:0] mem_addr_o,
    input  logic [NB_DATA-1:0] mem_data_i,
    output logic [2:0]         state_o
);

    localparam int unsigned N_BYTES = NB_DATA / NB_BYTE;
    localparam int unsigned NB_IDX  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    state_e             state_q, state_d;
    dump_phase_e        phase_q, phase_d;
    dump_step_e         step_q, step_d;
    logic [NB_IDX-1:0]  byte_cnt_q, byte_cnt_d;
    logic [NB_DATA-1:0] word_q, word_d;
    logic               we_q, we_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic               en_q, en_d;
    logic [NB_REG-1:0]  reg_addr_q, reg_addr_d;
    logic [NB_ADDR-1:0] mem_addr_q, mem_addr_d;
`ifdef DEBUG_CYCLE_COUNT_EN
    logic [NB_DATA-1:0] cnt_q, cnt_d;
`endif

    logic               word_start;
    logic [NB_DATA-1:0] word_val;
    logic               word_done;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        step_d     = step_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        en_d       = en_q;
        reg_addr_d = reg_addr_q;
        mem_addr_d = mem_addr_q;
        word_start = 1'b0;
        word_val   = '0;
`ifdef DEBUG_CYCLE_COUNT_EN
        cnt_d = en_q ? cnt_q + NB_DATA'(1) : cnt_q;
`endif

        unique case (state_q)
            StLoad: begin
                if (we_q) begin
                    addr_d = addr_q + NB_ADDR'(1);
                    // Memory full: the write just issued was the last address.
                    if (addr_q == {NB_ADDR{1'b1}}) state_d = StCmd;
                end
                if (rx_valid_i) begin
                    word_d = (word_q >> NB_BYTE) | (NB_DATA'(rx_data_i) << (NB_DATA - NB_BYTE));
                    if (byte_cnt_q == NB_IDX'(N_BYTES - 1)) begin
                        byte_cnt_d = '0;
                        if (word_d == END_OF_PROGRAM[NB_DATA-1:0]) begin
                            state_d = StCmd;
                            addr_d  = '0;
                        end else begin
                            we_d = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + NB_IDX'(1);
                    end
                end
            end
            StCmd: begin
                if (rx_valid_i) begin
                    case (rx_data_i)
                        CMD_STEP: begin
                            state_d = StStep;
                            en_d    = 1'b1;
                        end
                        CMD_RUN: begin
                            state_d = StRun;
                            en_d    = 1'b1;
                        end
                        CMD_DUMP: begin
                            state_d = StDump;
                            phase_d = PhPc;
                            step_d  = StepAddr;
                        end
                        CMD_LOAD: begin
                            state_d    = StLoad;
                            addr_d     = '0;
                            byte_cnt_d = '0;
`ifdef DEBUG_CYCLE_COUNT_EN
                            cnt_d = '0;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            StStep: begin
                en_d    = 1'b0;
                state_d = StDump;
                phase_d = PhPc;
                step_d  = StepAddr;
            end
            StRun: begin
                // halt and break together still make a single stop.
                if (halt_i || (rx_valid_i && rx_data_i == CMD_BREAK)) begin
                    en_d    = 1'b0;
                    state_d = StDump;
                    phase_d = PhPc;
                    step_d  = StepAddr;
                end
            end
            StDump: begin
                unique case (step_q)
                    // Address is on the port this cycle; read data is valid next cycle.
                    StepAddr: step_d = StepLatch;
                    StepLatch: begin
                        word_start = 1'b1;
                        step_d     = StepSend;
                        unique case (phase_q)
                            PhPc:  word_val = pc_i;
`ifdef DEBUG_CYCLE_COUNT_EN
                            PhCnt: word_val = cnt_q;
`else
                            PhCnt: word_val = '0;
`endif
                            PhReg: word_val = reg_data_i;
                            PhMem: word_val = mem_data_i;
                            default: word_val = '0;
                        endcase
                    end
                    StepSend: begin
                        if (word_done) begin
                            step_d = StepAddr;
                            unique case (phase_q)
`ifdef DEBUG_CYCLE_COUNT_EN
                                PhPc:  phase_d = PhCnt;
`else
                                PhPc:  phase_d = PhReg;
`endif
                                PhCnt: phase_d = PhReg;
                                PhReg: begin
                                    if (reg_addr_q == NB_REG'(N_REGISTER - 1)) begin
                                        reg_addr_d = '0;
                                        phase_d    = PhMem;
                                    end else begin
                                        reg_addr_d = reg_addr_q + NB_REG'(1);
                                    end
                                end
                                PhMem: begin
                                    if (mem_addr_q == NB_ADDR'(N_MEMORY_DATA - 1)) begin
                                        mem_addr_d = '0;
                                        phase_d    = PhPc;
                                        state_d    = StCmd;
                                    end else begin
                                        mem_addr_d = mem_addr_q + NB_ADDR'(1);
                                    end
                                end
                                default: phase_d = PhPc;
                            endcase
                        end
                    end
                    default: step_d = StepAddr;
                endcase
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= StLoad;
            phase_q    <= PhPc;
            step_q     <= StepAddr;
            byte_cnt_q <= '0;
            word_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            en_q       <= 1'b0;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
`ifdef DEBUG_CYCLE_COUNT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            step_q     <= step_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            en_q       <= en_d;
            reg_addr_q <= reg_addr_d;
            mem_addr_q <= mem_addr_d;
`ifdef DEBUG_CYCLE_COUNT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    debug_word_tx #(
        .NB_DATA(NB_DATA)
    ) u_word_tx (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .start_i   (word_start),
        .word_i    (word_val),
        .tx_data_o (tx_data_o),
        .tx_start_o(tx_start_o),
        .tx_done_i (tx_done_i),
        .done_o    (word_done)
    );

    assign instr_data_o  = word_q;
    assign instr_addr_o  = addr_q;
    assign instr_we_o    = we_q;
    assign en_pipeline_o = en_q;
    assign reg_sel_o     = (state_q == StDump);
    assign mem_sel_o     = (state_q == StDump);
    assign reg_addr_o    = reg_addr_q;
    assign mem_addr_o    = mem_addr_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_debug_ctrl_v2.sv
// Directed bench for debug_ctrl_v2: program load, commands, step/run/break dumps,
// tx back-pressure, reset mid-dump and memory-full load. Inputs change and outputs are
// sampled on the falling clock edge. Optional feature macro: DEBUG_CYCLE_COUNT_EN.
module tb_debug_ctrl_v2;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int NB_ADDR = 7;
`ifdef DEBUG_CYCLE_COUNT_EN
    localparam int N_WORDS = 2 + 32 + 128;
`else
    localparam int N_WORDS = 1 + 32 + 128;
`endif

    logic               clock = 1'b0;
    logic               reset_i;
    logic [7:0]         rx_data_i;
    logic               rx_valid_i;
    logic [7:0]         tx_data_o;
    logic               tx_start_o;
    logic               tx_done_i = 1'b0;
    logic [NB_DATA-1:0] instr_data_o;
    logic [NB_ADDR-1:0] instr_addr_o;
    logic               instr_we_o;
    logic               en_pipeline_o;
    logic               halt_i;
    logic [NB_DATA-1:0] pc_i;
    logic               reg_sel_o;
    logic [NB_REG-1:0]  reg_addr_o;
    logic [NB_DATA-1:0] reg_data_i = '0;
    logic               mem_sel_o;
    logic [NB_ADDR-1:0] mem_addr_o;
    logic [NB_DATA-1:0] mem_data_i = '0;
    logic [2:0]         state_o;

    int n_checks = 0;
    int n_fails  = 0;
    int tx_delay = 1;
    int n_start  = 0;
    int back2back = 0;
    int en_cnt   = 0;
    logic [7:0]         tx_q[$];
    logic [7:0]         exp_q[$];
    logic [NB_ADDR-1:0] we_addr_q[$];
    logic [NB_DATA-1:0] we_data_q[$];

    always #5 clock = ~clock;

    debug_ctrl_v2 dut (
        .clock_i      (clock),
        .reset_i      (reset_i),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .tx_data_o    (tx_data_o),
        .tx_start_o   (tx_start_o),
        .tx_done_i    (tx_done_i),
        .instr_data_o (instr_data_o),
        .instr_addr_o (instr_addr_o),
        .instr_we_o   (instr_we_o),
        .en_pipeline_o(en_pipeline_o),
        .halt_i       (halt_i),
        .pc_i         (pc_i),
        .reg_sel_o    (reg_sel_o),
        .reg_addr_o   (reg_addr_o),
        .reg_data_i   (reg_data_i),
        .mem_sel_o    (mem_sel_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_i   (mem_data_i),
        .state_o      (state_o)
    );

    function automatic logic [31:0] reg_val(input int a);
        return 32'hA000_0000 + 32'(a) * 32'h0001_0101;
    endfunction

    function automatic logic [31:0] mem_val(input int a);
        return 32'hB000_0000 + 32'(a) * 32'h0001_0203;
    endfunction

    function automatic logic [63:0] outs();
        return {tx_data_o, tx_start_o, instr_data_o, instr_addr_o, instr_we_o, en_pipeline_o,
                reg_sel_o, reg_addr_o, mem_sel_o, mem_addr_o};
    endfunction

    // Synchronous-read register file and data memory: data follows address by one cycle.
    initial begin
        logic [NB_REG-1:0]  ra = '0;
        logic [NB_ADDR-1:0] ma = '0;
        forever begin
            @(negedge clock);
            reg_data_i = reg_val(int'(ra));
            mem_data_i = mem_val(int'(ma));
            ra = reg_addr_o;
            ma = mem_addr_o;
        end
    end

    // UART tx model: tx_done_i pulses tx_delay cycles after each tx_start_o.
    initial begin
        int pend = 0;
        forever begin
            @(negedge clock);
            tx_done_i = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) tx_done_i = 1'b1;
            end
            if (tx_start_o) pend = tx_delay;
        end
    end

    // Byte capture, back-to-back start detection, write capture and enable counting.
    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clock);
            if (tx_start_o && prev) back2back++;
            prev = tx_start_o;
            if (tx_start_o) begin
                tx_q.push_back(tx_data_o);
                n_start++;
            end
            if (instr_we_o) begin
                we_addr_q.push_back(instr_addr_o);
                we_data_q.push_back(instr_data_o);
            end
            if (en_pipeline_o) en_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clock);
        rx_valid_i = 1'b0;
        @(negedge clock);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n = 0;
        while (state_o !== st && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, state_o, st);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic check_dump(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
        int bad = 0;
        int first = -1;
        exp_q.delete();
        push_word(pc);
`ifdef DEBUG_CYCLE_COUNT_EN
        push_word(cnt);
`endif
        for (int i = 0; i < 32; i++) push_word(reg_val(i));
        for (int i = 0; i < 128; i++) push_word(mem_val(i));
        $display("dump %s: %0d bytes expected, pc %h, cycle count %0d", tag, exp_q.size(), pc,
                 cnt);
        check({tag, "_len"}, 64'(tx_q.size()), 64'(N_WORDS * 4));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        check({tag, "_bytes_bad"}, 64'(bad), 64'd0);
        if (first >= 0) $display("  first differing byte index %0d", first);
    endtask

    initial begin
        int n;
        int bad;
        int snap;
        reset_i    = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = '0;
        halt_i     = 1'b0;
        pc_i       = '0;
        repeat (2) @(negedge clock);
        check("reset_state", state_o, 3'd0);
        check("reset_outputs", outs(), 64'd0);
        reset_i = 1'b0;
        @(negedge clock);

        // Program load with terminator.
        send_word(32'h1234_5678);
        send_word(32'hDEAD_BEEF);
        send_word(32'hFFFF_FFFF);
        repeat (2) @(negedge clock);
        check("load_writes", 64'(we_addr_q.size()), 64'd2);
        check("load_w0_addr", (we_addr_q.size() > 0) ? we_addr_q[0] : 'x, 64'd0);
        check("load_w0_data", (we_data_q.size() > 0) ? we_data_q[0] : 'x, 64'h1234_5678);
        check("load_w1_addr", (we_addr_q.size() > 1) ? we_addr_q[1] : 'x, 64'd1);
        check("load_w1_data", (we_data_q.size() > 1) ? we_data_q[1] : 'x, 64'hDEAD_BEEF);
        check("load_state", state_o, 3'd1);
        check("load_addr_back0", instr_addr_o, 64'd0);

        send_byte(8'h07);
        check("cmd_ignore", state_o, 3'd1);

        // Single step, with a byte arriving mid-dump that must be dropped.
        pc_i = 32'h4; en_cnt = 0; tx_q.delete(); tx_delay = 1;
        send_byte(8'h01);
        check("step_state", state_o, 3'd4);
        check("step_sel_en", {reg_sel_o, mem_sel_o, en_pipeline_o}, 64'b110);
        send_byte(8'h02);
        wait_state("step_end", 3'd1, 10000);
        check("step_en_cycles", 64'(en_cnt), 64'd1);
        check_dump("step", 32'h4, 32'd1);

        // Run until halt after 10 enabled cycles.
        pc_i = 32'h40; en_cnt = 0; tx_q.delete();
        send_byte(8'h02);
        repeat (8) @(negedge clock);
        check("run_en_before_halt", en_pipeline_o, 64'd1);
        halt_i = 1'b1;
        @(negedge clock);
        halt_i = 1'b0;
        check("run_en_dropped", en_pipeline_o, 64'd0);
        check("run_state_dump", state_o, 3'd4);
        wait_state("run_end", 3'd1, 10000);
        check("run_en_cycles", 64'(en_cnt), 64'd10);
        check_dump("run", 32'h40, 32'd11);

        // Break by rx 0x05 after an ignored byte.
        pc_i = 32'h80; en_cnt = 0; tx_q.delete();
        send_byte(8'h02);
        send_byte(8'h33);
        send_byte(8'h05);
        check("brk_state", state_o, 3'd4);
        wait_state("brk_end", 3'd1, 10000);
        check("brk_en_cycles", 64'(en_cnt), 64'd4);
        check_dump("brk", 32'h80, 32'd15);

        // Halt and break together under heavy tx back-pressure.
        pc_i = 32'h100; en_cnt = 0; tx_q.delete(); tx_delay = 100; back2back = 0;
        send_byte(8'h02);
        rx_data_i = 8'h05; rx_valid_i = 1'b1; halt_i = 1'b1;
        @(negedge clock);
        rx_valid_i = 1'b0; halt_i = 1'b0;
        check("bp_state", state_o, 3'd4);
        check("bp_en_dropped", en_pipeline_o, 64'd0);
        wait_state("bp_end", 3'd1, 90000);
        check("bp_en_cycles", 64'(en_cnt), 64'd2);
        check("bp_back2back", 64'(back2back), 64'd0);
        check_dump("bp", 32'h100, 32'd17);
        n = tx_q.size();
        check("bp_last_word", (n >= 4) ? {tx_q[n-1], tx_q[n-2], tx_q[n-3], tx_q[n-4]} : 'x,
              64'(mem_val(127)));

        // Reset in the middle of the register bytes.
        tx_delay = 2; tx_q.delete();
        send_byte(8'h03);
        n = 0;
        while (tx_q.size() < 14 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check("rst_dump_progress", 64'(tx_q.size() >= 14), 64'd1);
        reset_i = 1'b1;
        @(negedge clock);
        check("rst_state", state_o, 3'd0);
        check("rst_outputs", outs(), 64'd0);
        snap = n_start;
        @(negedge clock);
        reset_i = 1'b0;
        repeat (20) @(negedge clock);
        check("rst_no_tx_start", 64'(n_start), 64'(snap));
        check("rst_state_after", state_o, 3'd0);

        // Fill the whole instruction memory without a terminator.
        we_addr_q.delete(); we_data_q.delete();
        for (int i = 0; i < 128; i++) send_word(32'h1000_0000 + 32'(i));
        repeat (2) @(negedge clock);
        check("full_writes", 64'(we_addr_q.size()), 64'd128);
        bad = 0;
        for (int i = 0; i < we_addr_q.size(); i++) begin
            if (we_addr_q[i] !== NB_ADDR'(i) || we_data_q[i] !== 32'h1000_0000 + 32'(i)) bad++;
        end
        check("full_write_bad", 64'(bad), 64'd0);
        check("full_state", state_o, 3'd1);
        check("full_addr_wrap", instr_addr_o, 64'd0);

        send_byte(8'h04);
        check("cmd_load_state", state_o, 3'd0);
        check("cmd_load_addr", instr_addr_o, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
